// File: rtl/alu_result_stage_pkg.sv
// Shared ALU control codes and classification helpers for the result stage.

// Branch-class test: true for the six conditional-branch ALU operations.
`define ALU_CTRL_IS_BRANCH(op) ((op) inside {ALU_CTRL_BEQ, ALU_CTRL_BNE, ALU_CTRL_BLT, \
                                             ALU_CTRL_BGE, ALU_CTRL_BLTU, ALU_CTRL_BGEU})

package alu_result_stage_pkg;

  localparam int ALU_CTRL_WIDTH = 5;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_ADD    = 5'd0;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SUB    = 5'd1;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SLL    = 5'd2;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SLT    = 5'd3;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SLTU   = 5'd4;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_XOR    = 5'd5;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SRL    = 5'd6;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SRA    = 5'd7;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_OR     = 5'd8;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_AND    = 5'd9;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BEQ    = 5'd10;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BNE    = 5'd11;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BLT    = 5'd12;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BGE    = 5'd13;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BLTU   = 5'd14;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BGEU   = 5'd15;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MUL    = 5'd16;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MULH   = 5'd17;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MULHSU = 5'd18;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MULHU  = 5'd19;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_DIV    = 5'd20;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_DIVU   = 5'd21;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_REM    = 5'd22;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_REMU   = 5'd23;

  function automatic logic is_branch_op(input logic [ALU_CTRL_WIDTH-1:0] op);
    return `ALU_CTRL_IS_BRANCH(op);
  endfunction

endpackage

// File: rtl/alu_result_stage_skid_buffer.sv
// Two-entry valid/ready skid buffer with synchronous flush.
// in_ready comes straight from a register, so it never depends on out_ready.

module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             r_main_valid, r_skid_valid;
  logic [WIDTH-1:0] r_main, r_skid;
  logic             w_in_fire;

  assign in_ready  = !r_skid_valid;
  assign out_valid = r_main_valid;
  assign out_data  = r_main;
  assign w_in_fire = in_valid && !r_skid_valid;

  // Occupancy: skid is only ever filled while main is stalled, so skid implies main.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid) begin
      if (out_ready) r_skid_valid <= 1'b0;
    end else if (r_main_valid) begin
      if (out_ready)      r_main_valid <= w_in_fire;
      else if (w_in_fire) r_skid_valid <= 1'b1;
    end else begin
      r_main_valid <= w_in_fire;
    end
  end

  // Payload: no reset needed, qualified by the valid bits above.
  always_ff @(posedge clk) begin
    if (r_skid_valid) begin
      if (out_ready) r_main <= r_skid;
    end else if (w_in_fire && (!r_main_valid || out_ready)) begin
      r_main <= in_data;
    end
    if (w_in_fire && r_main_valid && !out_ready) r_skid <= in_data;
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: classifies each ALU result as write-back or branch,
// buffers it in a 2-entry skid buffer and counts retired entries.

module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_result,
  input  logic [ALU_CTRL_WIDTH-1:0] in_alucontrol,
  input  logic [4:0]                in_rd,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [XLEN-1:0]           in_imm,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_we,
  output logic [4:0]                out_rd,
  output logic [XLEN-1:0]           out_wdata,
  output logic                      out_is_branch,
  output logic                      out_taken,
  output logic [XLEN-1:0]           out_target,
  output logic [CNT_WIDTH-1:0]      retired_cnt
);

  // {we, rd, wdata, is_branch, taken, target}
  localparam int PW = 2 * XLEN + 8;

  logic                 w_is_branch, w_we;
  logic [PW-1:0]        w_in_pay, w_out_pay;
  logic                 w_hd_we, w_hd_br, w_hd_tk;
  logic [CNT_WIDTH-1:0] r_retired_cnt;

  assign w_is_branch = is_branch_op(in_alucontrol);
  assign w_we        = !w_is_branch && (in_rd != 5'd0);
  assign w_in_pay    = {w_we, in_rd, in_result, w_is_branch, in_result[0], in_pc + in_imm};

  skid_buffer #(.WIDTH(PW)) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_pay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_pay)
  );

  assign {w_hd_we, out_rd, out_wdata, w_hd_br, w_hd_tk, out_target} = w_out_pay;

  // Control flags are masked so an empty stage never advertises a write or branch.
  assign out_we        = out_valid && w_hd_we;
  assign out_is_branch = out_valid && w_hd_br;
  assign out_taken     = out_valid && w_hd_tk;
  assign retired_cnt   = r_retired_cnt;

  // Retired counter: every output transfer, flush cycle included; wraps naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                     r_retired_cnt <= '0;
    else if (out_valid && out_ready) r_retired_cnt <= r_retired_cnt + 1'b1;
  end

endmodule
